// File: rtl/apbmem_arbiter.sv
// Two-requester APB3 arbiter in front of one downstream APB completer (apbmem scratch RAM).
// Define APB_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module apbmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     s_psel_i,
    input  logic [1:0]                     s_penable_i,
    input  logic [1:0]                     s_pwrite_i,
    input  logic [1:0][ADDR_W-1:0]         s_paddr_i,
    input  logic [1:0][DATA_W-1:0]         s_pwdata_i,
    input  logic [1:0][2:0]                s_pprot_i,
    input  logic [1:0][DATA_W/8-1:0]       s_pstrb_i,
    output logic [1:0][DATA_W-1:0]         s_prdata_o,
    output logic [1:0]                     s_pready_o,
    output logic [1:0]                     s_pslverr_o,
    output logic                           m_psel_o,
    output logic                           m_penable_o,
    output logic                           m_pwrite_o,
    output logic [ADDR_W-1:0]              m_paddr_o,
    output logic [DATA_W-1:0]              m_pwdata_o,
    output logic [2:0]                     m_pprot_o,
    output logic [DATA_W/8-1:0]            m_pstrb_o,
    input  logic [DATA_W-1:0]              m_prdata_i,
    input  logic                           m_pready_i,
    input  logic                           m_pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state_q;
    logic   gnt_q;
    logic   gnt_d;
    logic   m_psel_q;
    logic   m_penable_q;

    // Requests are psel alone; the requester's own penable phase carries no information here.
    logic unused_penable;
    assign unused_penable = ^s_penable_i;

`ifdef APB_ARB_RR_EN
    logic last_q;

    always_comb begin
        gnt_d = ~s_psel_i[0];
        if (&s_psel_i) begin
            gnt_d = ~last_q;
        end
    end
`else
    always_comb begin
        gnt_d = ~s_psel_i[0];
    end
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
`ifdef APB_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|s_psel_i) begin
                        gnt_q    <= gnt_d;
                        m_psel_q <= 1'b1;
                        state_q  <= SETUP;
`ifdef APB_ARB_RR_EN
                        last_q   <= gnt_d;
`endif
                    end
                end
                SETUP: begin
                    m_penable_q <= 1'b1;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    if (m_pready_i) begin
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    m_psel_q    <= 1'b0;
                    m_penable_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign m_psel_o    = m_psel_q;
    assign m_penable_o = m_penable_q;

    // NOTE: every output gets a default before the conditional drive, so no latch is inferred.
    always_comb begin
        m_pwrite_o  = 1'b0;
        m_paddr_o   = '0;
        m_pwdata_o  = '0;
        m_pprot_o   = '0;
        m_pstrb_o   = '0;
        s_prdata_o  = '0;
        s_pready_o  = '0;
        s_pslverr_o = '0;
        if (state_q != IDLE) begin
            m_pwrite_o = s_pwrite_i[gnt_q];
            m_paddr_o  = s_paddr_i[gnt_q];
            m_pwdata_o = s_pwdata_i[gnt_q];
            m_pprot_o  = s_pprot_i[gnt_q];
            m_pstrb_o  = s_pstrb_i[gnt_q];
        end
        if (state_q == ACCESS) begin
            s_pready_o[gnt_q]  = m_pready_i;
            s_prdata_o[gnt_q]  = m_prdata_i;
            s_pslverr_o[gnt_q] = m_pslverr_i;
        end
    end

endmodule

// File: tb/tb_apbmem_arbiter.sv
// Scoreboard bench for apbmem_arbiter: two APB requester drivers, a behavioural apbmem
// completer with programmable waits, and a monitor checking every completion against a reference.
module tb_apbmem_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        s_psel_i;
    logic [1:0]        s_penable_i;
    logic [1:0]        s_pwrite_i;
    logic [1:0][31:0]  s_paddr_i;
    logic [1:0][31:0]  s_pwdata_i;
    logic [1:0][2:0]   s_pprot_i;
    logic [1:0][3:0]   s_pstrb_i;
    logic [1:0][31:0]  s_prdata_o;
    logic [1:0]        s_pready_o;
    logic [1:0]        s_pslverr_o;
    logic              m_psel_o;
    logic              m_penable_o;
    logic              m_pwrite_o;
    logic [31:0]       m_paddr_o;
    logic [31:0]       m_pwdata_o;
    logic [2:0]        m_pprot_o;
    logic [3:0]        m_pstrb_o;
    logic [31:0]       m_prdata_i;
    logic              m_pready_i;
    logic              m_pslverr_i;

    logic        req_psel  [2];
    logic        req_pen   [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_prot  [2];
    logic [3:0]  req_strb  [2];

    assign s_psel_i    = {req_psel[1], req_psel[0]};
    assign s_penable_i = {req_pen[1], req_pen[0]};
    assign s_pwrite_i  = {req_write[1], req_write[0]};
    assign s_paddr_i   = {req_addr[1], req_addr[0]};
    assign s_pwdata_i  = {req_wdata[1], req_wdata[0]};
    assign s_pprot_i   = {req_prot[1], req_prot[0]};
    assign s_pstrb_i   = {req_strb[1], req_strb[0]};

    apbmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_psel_i    (s_psel_i),
        .s_penable_i (s_penable_i),
        .s_pwrite_i  (s_pwrite_i),
        .s_paddr_i   (s_paddr_i),
        .s_pwdata_i  (s_pwdata_i),
        .s_pprot_i   (s_pprot_i),
        .s_pstrb_i   (s_pstrb_i),
        .s_prdata_o  (s_prdata_o),
        .s_pready_o  (s_pready_o),
        .s_pslverr_o (s_pslverr_o),
        .m_psel_o    (m_psel_o),
        .m_penable_o (m_penable_o),
        .m_pwrite_o  (m_pwrite_o),
        .m_paddr_o   (m_paddr_o),
        .m_pwdata_o  (m_pwdata_o),
        .m_pprot_o   (m_pprot_o),
        .m_pstrb_o   (m_pstrb_o),
        .m_prdata_i  (m_prdata_i),
        .m_pready_i  (m_pready_i),
        .m_pslverr_i (m_pslverr_i)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] rdata;
        bit          slverr;
        int          lat;
        int          issue_cyc;
    } item_t;

    item_t       sb_q0[$];
    item_t       sb_q1[$];
    int          order_q[$];
    int          setup_q[$];
    int          done_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] cmem [int];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cfg_waits = 0;
    bit rand_waits = 0;
    bit done_prev = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

    // Behavioural apbmem: word-addressed 64KB, 0x?E??? region answers with an error.
    initial begin
        int wcnt;
        int tgt;
        bit first;
        int word;
        m_pready_i  = 1'b0;
        m_prdata_i  = '0;
        m_pslverr_i = 1'b0;
        wcnt = 0;
        tgt = 0;
        first = 1;
        forever begin
            @(posedge clk);
            #2;
            m_pready_i  = 1'b0;
            m_prdata_i  = '0;
            m_pslverr_i = 1'b0;
            if (!(m_psel_o && m_penable_o)) begin
                first = 1;
                wcnt = 0;
            end else begin
                if (first) begin
                    tgt = rand_waits ? int'($urandom_range(0, 5)) : cfg_waits;
                    first = 0;
                    wcnt = 0;
                end
                if (wcnt >= tgt) begin
                    m_pready_i = 1'b1;
                    first = 1;
                    word = int'(m_paddr_o[15:2]);
                    if (m_paddr_o[15:12] == 4'hE) begin
                        m_pslverr_i = 1'b1;
                    end else if (m_pwrite_o) begin
                        cmem[word] = merge(cmem.exists(word) ? cmem[word] : 32'h0,
                                           m_pwdata_o, m_pstrb_o);
                    end else begin
                        m_prdata_i = cmem.exists(word) ? cmem[word] : 32'h0;
                    end
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // One APB transfer from requester r; lat < 0 skips the latency comparison.
    task automatic do_xfer(input int r, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot, input int lat);
        item_t it;
        int    n;
        int    word;
        bit    err;
        word = int'(addr[15:2]);
        err  = (addr[15:12] == 4'hE);
        it.wr = wr;
        it.addr = addr;
        it.wdata = wdata;
        it.strb = strb;
        it.prot = prot;
        it.slverr = err;
        it.rdata = '0;
        it.lat = lat;
        it.issue_cyc = cyc;
        if (!err) begin
            if (wr) ref_mem[word] = merge(ref_mem.exists(word) ? ref_mem[word] : 32'h0, wdata, strb);
            else    it.rdata = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
        end
        if (r == 0) sb_q0.push_back(it);
        else        sb_q1.push_back(it);
        req_psel[r]  = 1'b1;
        req_pen[r]   = 1'b0;
        req_write[r] = wr;
        req_addr[r]  = addr;
        req_wdata[r] = wdata;
        req_strb[r]  = strb;
        req_prot[r]  = prot;
        @(posedge clk);
        #1 req_pen[r] = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_pready_o[r]) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL timeout req%0d addr=%h: got no pready, expected pready within 200 cycles", r, addr);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_psel[r] = 1'b0;
        req_pen[r]  = 1'b0;
    endtask

    task automatic rand_traffic(input int r, input int n);
        logic [31:0] a;
        logic [31:0] u;
        for (int i = 0; i < n; i++) begin
            u = $urandom();
            a = {u[31:16], 16'h0};
            a[15:12] = ($urandom_range(0, 7) == 0) ? 4'hE : 4'h0;
            a[11:8]  = (r == 0) ? 4'h4 : 4'h5;
            a[5:2]   = 4'($urandom_range(0, 15));
            do_xfer(r, bit'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each completion and checks bus invariants every cycle.
    always @(negedge clk) begin
        item_t it;
        bit    have;
        if (!rst) begin
            if (done_prev) check("psel_gap", 64'(m_psel_o), 64'h0);
            done_prev = 0;
            if (m_psel_o && !m_penable_o) setup_q.push_back(cyc);
            if (!m_psel_o) begin
                check("idle_mctl", {m_penable_o, m_pwrite_o, m_pprot_o, m_pstrb_o, m_paddr_o}, 64'h0);
                check("idle_mwdata", 64'(m_pwdata_o), 64'h0);
            end
            if (|s_pready_o) check("pready_onehot", 64'($countones(s_pready_o)), 64'h1);
            for (int r = 0; r < 2; r++) begin
                if (!s_pready_o[r]) begin
                    check($sformatf("quiet_rsp%0d", r), {s_pslverr_o[r], s_prdata_o[r]}, 64'h0);
                end else begin
                    done_prev = 1;
                    order_q.push_back(r);
                    done_q.push_back(cyc);
                    have = 0;
                    if (r == 0 && sb_q0.size() > 0) begin it = sb_q0.pop_front(); have = 1; end
                    if (r == 1 && sb_q1.size() > 0) begin it = sb_q1.pop_front(); have = 1; end
                    if (!have) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pready req%0d: got pready=1, expected no outstanding transfer", r);
                    end else begin
                        check("acc_phase", {m_psel_o, m_penable_o}, 64'h3);
                        check("m_paddr", 64'(m_paddr_o), 64'(it.addr));
                        check("m_pwrite", 64'(m_pwrite_o), 64'(it.wr));
                        check("m_pprot", 64'(m_pprot_o), 64'(it.prot));
                        check("m_pwdata_strb", {m_pstrb_o, m_pwdata_o}, {it.strb, it.wdata});
                        check($sformatf("prdata%0d", r), 64'(s_prdata_o[r]), 64'(it.rdata));
                        check($sformatf("pslverr%0d", r), 64'(s_pslverr_o[r]), 64'(it.slverr));
                        if (it.lat >= 0) check("latency", 64'(cyc - it.issue_cyc), 64'(it.lat));
                    end
                end
            end
        end
    end

    initial begin
        int exp_order[8];
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req_psel[r] = 0; req_pen[r] = 0; req_write[r] = 0; req_addr[r] = '0;
            req_wdata[r] = '0; req_prot[r] = '0; req_strb[r] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_mctl", {m_psel_o, m_penable_o, m_paddr_o}, 64'h0);
        check("reset_srsp", {s_pready_o, s_pslverr_o}, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester, 0 and 3 downstream waits.
        cfg_waits = 0;
        do_xfer(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 2);
        do_xfer(0, 0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 2);
        cfg_waits = 3;
        do_xfer(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd1, 5);
        do_xfer(0, 0, 32'h0000_0010, 32'h0, 4'h0, 3'd1, 5);
        cfg_waits = 0;
        do_xfer(1, 1, 32'h0000_0020, 32'h1122_3344, 4'b0101, 3'd5, 2);
        do_xfer(1, 0, 32'h0000_0020, 32'h0, 4'h0, 3'd5, 2);
        cfg_waits = 1;
        do_xfer(0, 0, 32'h0000_E040, 32'h0, 4'h0, 3'd3, 3);
        do_xfer(1, 1, 32'h0000_E044, 32'h5555_AAAA, 4'hF, 3'd4, 3);

        // Req1 asks while req0 is in ACCESS: one idle cycle before req1's SETUP.
        cfg_waits = 3;
        setup_q.delete();
        done_q.delete();
        fork
            do_xfer(0, 1, 32'h0000_0080, 32'hA5A5_5A5A, 4'hF, 3'd2, 5);
            begin
                repeat (3) @(posedge clk);
                #1 do_xfer(1, 0, 32'h0000_0080, 32'h0, 4'h0, 3'd6, -1);
            end
        join
        if (setup_q.size() >= 2 && done_q.size() >= 1) begin
            check("handover_gap", 64'(setup_q[1] - done_q[0]), 64'h2);
        end else begin
            total++;
            bad++;
            $display("FAIL handover_events: got %0d setups/%0d completions, expected 2/1", setup_q.size(), done_q.size());
        end

        // Reset in the middle of a req0 write: transfer abandoned, RAM untouched.
        req_psel[0] = 1'b1; req_pen[0] = 1'b0; req_write[0] = 1'b1;
        req_addr[0] = 32'h0000_0010; req_wdata[0] = 32'hCAFE_F00D; req_strb[0] = 4'hF;
        @(posedge clk);
        #1 req_pen[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_access", {m_psel_o, m_penable_o}, 64'h3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_psel[0] = 1'b0;
        req_pen[0]  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_mctl", {m_psel_o, m_penable_o}, 64'h0);
        check("rst_mid_pready", 64'(s_pready_o), 64'h0);
        @(posedge clk);
        #1;
        cfg_waits = 0;
        do_xfer(1, 0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 2);

        // Tie: both requesters start together, four transfers each.
        pulse_reset();
        order_q.delete();
        fork
            for (int i = 0; i < 4; i++) do_xfer(0, i[0], 32'h600 + 32'(4*i), 32'h6000 + 32'(i), 4'hF, 3'd0, -1);
            for (int i = 0; i < 4; i++) do_xfer(1, i[0], 32'h700 + 32'(4*i), 32'h7000 + 32'(i), 4'hF, 3'd0, -1);
        join
`ifdef APB_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        check("tie_count", 64'(order_q.size()), 64'h8);
        for (int i = 0; i < 8 && i < order_q.size(); i++) begin
            check($sformatf("tie_order[%0d]", i), 64'(order_q[i]), 64'(exp_order[i]));
        end

        // Random concurrent traffic with random waits and error-region hits.
        rand_waits = 1;
        fork
            rand_traffic(0, 30);
            rand_traffic(1, 30);
        join
        rand_waits = 0;

        repeat (5) @(posedge clk);
        #1;
        check("sb_drain", 64'(sb_q0.size() + sb_q1.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
